// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 16-bit unsigned multiply / divide unit.
// Produces one result bit per clock over 16 cycles. The result is then
// written back to the register file through WR/WD/RegWrite for a single cycle.
module muldiv_unit #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [ADDR-1:0]  dest,
    output logic             busy,
    output logic             done,
    output logic [ADDR-1:0]  WR,
    output logic [WIDTH-1:0] WD,
    output logic             RegWrite
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state, state_next;

    logic             op_r;
    logic [ADDR-1:0]  dest_r;
    logic [WIDTH-1:0] a_r;      // multiplicand (shifts left) / dividend (shifts out MSB-first)
    logic [WIDTH-1:0] b_r;      // multiplier (shifts right) / divisor (static)
    logic [WIDTH-1:0] acc;      // product accumulator / quotient
    logic [WIDTH-1:0] rem;      // partial remainder; always < divisor, so its top bit is implicit 0
    logic [4:0]       cnt;

    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] res_next;
    logic             last_iter;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: derived only from the state register, so no input-to-output paths
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        RegWrite = 1'b0;
        case (state)
            RUN: busy = 1'b1;
            WB: begin
                busy     = 1'b1;
                done     = 1'b1;
                RegWrite = 1'b1;
            end
            default: ;
        endcase
    end

    // One iteration step: shift-add for multiply, restoring trial subtract for divide
    always_comb begin
        last_iter = (cnt == 5'd15);
        mul_sum   = acc + (b_r[0] ? a_r : '0);
        rem_shift = {rem, a_r[WIDTH-1]};
        diff      = rem_shift - {1'b0, b_r};
        qbit      = ~diff[WIDTH];
        rem_next  = qbit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        res_next  = op_r ? {acc[WIDTH-2:0], qbit} : mul_sum;
    end

    // Datapath registers and registered write-back port
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_r   <= 1'b0;
            dest_r <= '0;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            rem    <= '0;
            cnt    <= '0;
            WR     <= '0;
            WD     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        dest_r <= dest;
                        a_r    <= a;
                        b_r    <= b;
                        acc    <= '0;
                        rem    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    acc <= res_next;
                    a_r <= {a_r[WIDTH-2:0], 1'b0};
                    if (op_r) begin
                        rem <= rem_next;
                    end else begin
                        b_r <= {1'b0, b_r[WIDTH-1:1]};
                    end
                    // Load the write-back port with the final bit folded in, so WD is valid in WB
                    if (last_iter) begin
                        WR <= dest_r;
                        WD <= res_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
